memory_stage: RTL

Memory (M) stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage. It consumes the EX/MEM register outputs, performs loads and stores over a req/ack data-memory port with variable latency, and stalls the pipeline while an access is outstanding. It aligns store data and byte enables, sign- or zero-extends load data, and owns the MEM/WB pipeline register that feeds writeback.

---
 rtl/memory_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: req/ack data-memory access with
// stall, store lane alignment, load extension and the MEM/WB pipeline register.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic [1:0]  wbselM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] pc4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        misalignedM,
  output logic        regwriteW,
  output logic [1:0]  wbselW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUresW,
  output logic [31:0] readdataW,
  output logic [31:0] pc4W
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT       state, stateNext;
  logic        isLoad, isStore, isAccess, badAlign, validAccess;
  logic [1:0]  off;
  logic [3:0]  beLane;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  assign off         = ALUresM[1:0];
  assign isLoad      = (wbselM == 2'b00) && regwriteM;
  assign isStore     = memrwM;
  assign isAccess    = isLoad || isStore;
  assign badAlign    = ((funct3M[1:0] == 2'b01) && off[0]) ||
                       ((funct3M[1:0] == 2'b10) && (off != 2'b00));
  assign validAccess = isAccess && !badAlign;

  // Gated by rst_n so request, stall and fault flags drop the moment reset asserts.
  assign misalignedM = rst_n && isAccess && badAlign;

  always_comb begin
    stateNext = state;
    dmem_req  = 1'b0;
    stallM    = 1'b0;
    case (state)
      IDLE: begin
        if (validAccess) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            stallM    = 1'b1;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        stallM   = !dmem_ack;
        if (dmem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (!rst_n) begin
      dmem_req = 1'b0;
      stallM   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    beLane     = 4'b1111;
    dmem_wdata = data_writeM;
    case (funct3M[1:0])
      2'b00: begin
        beLane     = 4'b0001 << off;
        dmem_wdata = {4{data_writeM[7:0]}};
      end
      2'b01: begin
        beLane     = 4'b0011 << off;
        dmem_wdata = {2{data_writeM[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_we   = dmem_req && isStore;
  assign dmem_be   = dmem_we ? beLane : 4'b0000;
  assign dmem_addr = {ALUresM[31:2], 2'b00};

  assign byteSel = dmem_rdata[{off, 3'b000} +: 8];
  assign halfSel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3M)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = dmem_rdata;
    endcase
  end

  // A stalled cycle pushes a bubble into W; the held M instruction retires later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW <= 1'b0;
      wbselW    <= 2'b00;
      rdW       <= 5'd0;
      ALUresW   <= 32'd0;
      readdataW <= 32'd0;
      pc4W      <= 32'd0;
    end else if (stallM) begin
      regwriteW <= 1'b0;
      wbselW    <= 2'b00;
      rdW       <= 5'd0;
      ALUresW   <= 32'd0;
      readdataW <= 32'd0;
      pc4W      <= 32'd0;
    end else begin
      regwriteW <= regwriteM && !misalignedM;
      wbselW    <= wbselM;
      rdW       <= rdM;
      ALUresW   <= ALUresM;
      readdataW <= (isLoad && !badAlign) ? loadData : 32'd0;
      pc4W      <= pc4M;
    end
  end

endmodule
